// File: rtl/spi_multiplier.sv
// SPI-slave multiplier peripheral. The master shifts in two WIDTH-bit operands
// (A then B, MSB first). A sequential shift-add datapath forms the 2*WIDTH-bit
// product, which the master then clocks back out on MISO, MSB first.
// Define SPI_MULT_SIGNED_EN to treat the operands and the product as two's complement.
module spi_multiplier #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic CS,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO,
  output logic BUSY
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(PW + 1);

  typedef enum logic [1:0] {StIdle, StRx, StMul, StTx} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_prev, sclk_rise, sclk_fall, mosi_bit, cs_act;

  state_e           state;
  logic [PW-2:0]    rx_sr;
  logic [PW-1:0]    mcand, acc, tx_sr;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             pending;

  logic [PW-1:0]    rx_nx, addend, acc_nx, a_ext;
  logic             mul_last;

  // Synchronise the pins, then register edge pulses with MOSI and CS kept aligned to them
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_prev <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      mosi_bit  <= 1'b0;
      cs_act    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
      sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
      mosi_bit  <= mosi_sync[SYNC_STAGES-1];
      cs_act    <= cs_sync[SYNC_STAGES-1];
    end
  end

  // Next RX word, operand extension and the shift-add step
  always_comb begin
    rx_nx    = {rx_sr, mosi_bit};
`ifdef SPI_MULT_SIGNED_EN
    a_ext    = {{WIDTH{rx_nx[PW-1]}}, rx_nx[PW-1:WIDTH]};
`else
    a_ext    = {{WIDTH{1'b0}}, rx_nx[PW-1:WIDTH]};
`endif
    mul_last = (cnt == CW'(WIDTH - 1));
    addend   = mplier[0] ? mcand : '0;
`ifdef SPI_MULT_SIGNED_EN
    // The multiplier MSB carries negative weight, so its partial product is subtracted
    acc_nx   = mul_last ? (acc - addend) : (acc + addend);
`else
    acc_nx   = acc + addend;
`endif
  end

  // Frame FSM: receive operands, multiply, shift the product out
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= StIdle;
      rx_sr   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      tx_sr   <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      BUSY    <= 1'b0;
    end else if (!cs_act) begin
      // Deselect discards any partial frame or product
      state   <= StIdle;
      rx_sr   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      tx_sr   <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          state <= StRx;
          cnt   <= '0;
          rx_sr <= '0;
        end
        StRx: begin
          if (sclk_rise) begin
            rx_sr <= rx_nx[PW-2:0];
            if (cnt == CW'(PW - 1)) begin
              mcand  <= a_ext;
              mplier <= rx_nx[WIDTH-1:0];
              acc    <= '0;
              cnt    <= '0;
              BUSY   <= 1'b1;
              state  <= StMul;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        StMul: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (mul_last) begin
            tx_sr   <= acc_nx;
            pending <= 1'b0;
            BUSY    <= 1'b0;
            state   <= StTx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StTx: begin
          // Shift only on a fall that follows a rise, so MISO is stable when the master samples
          if (sclk_fall && pending) begin
            tx_sr   <= tx_sr << 1;
            pending <= 1'b0;
          end else if (sclk_rise) begin
            pending <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // tx_sr is zero outside TX, so MISO idles low
  assign MISO = tx_sr[PW-1];

endmodule
